// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle for the multi-cycle RV32I core: instruction and
// status inputs from the datapath, mux selects, enables and the memory request.
interface multicycle_control_if;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  result_src;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    // Control FSM side: drives selects and enables, reads instr/flags.
    modport master (
        input  instr, zero, mem_ready,
        output mem_req, mem_we, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, alu_op, funct3, funct7
    );

    // Datapath side.
    modport slave (
        output instr, zero, mem_ready,
        input  mem_req, mem_we, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, alu_op, funct3, funct7
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for a shared-memory RV32I datapath. Sequences each
// instruction through fetch/decode/execute/memory/writeback, Moore-decodes
// every datapath control, flags illegal opcodes and counts retirements.
module multicycle_control #(
    parameter bit TRAP_HALT = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus,
    output logic                 o_illegal,
    output logic [CNT_W-1:0]     o_instret
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_JALR   = 4'd11,
        S_LUI    = 4'd12,
        S_AUIPC  = 4'd13,
        S_IDLE   = 4'd14,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t           r_state;
    state_t           w_next;
    logic             r_illegal;
    logic [CNT_W-1:0] r_instret;
    logic             w_retire;

    logic       w_mem_req, w_mem_we, w_ir_write, w_pc_write, w_reg_write;
    logic [1:0] w_alu_src_a, w_alu_src_b, w_result_src, w_alu_op;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    // Register fields the controller never inspects (rd, rs1, rs2).
    logic w_unused_instr;
    assign w_unused_instr = ^{bus.instr[24:15], bus.instr[11:7]};

    // State register; reset parks the FSM in IDLE so mem_req drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; mem_ready only matters in the three memory states.
    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch forms.
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  if (bus.mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                unique case (bus.instr[6:0])
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXEC_R;
                    OP_I:              w_next = S_EXEC_I;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI:            w_next = S_LUI;
                    OP_AUIPC:          w_next = S_AUIPC;
                    default:           w_next = S_TRAP;
                endcase
            end
            // Loads and stores differ only in opcode bit 5.
            S_MEMADR: w_next = bus.instr[5] ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.mem_ready) w_next = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) w_next = S_FETCH;
            S_EXEC_R,
            S_EXEC_I: w_next = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JAL,
            S_JALR, S_LUI, S_AUIPC: w_next = S_FETCH;
            S_TRAP:   w_next = TRAP_HALT ? S_TRAP : S_FETCH;
            default:  w_next = S_IDLE;
        endcase
    end

    // Moore output decode; FETCH/BRANCH enables also qualify on mem_ready/zero.
    always_comb begin
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_result_src = 2'b00;
        w_alu_op     = 2'b00;
        w_funct3     = 3'b000;
        w_funct7     = 7'b0000000;
        unique case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = bus.mem_ready;
                w_pc_write   = bus.mem_ready;
            end
            S_DECODE: begin
                // Branch target oldPC+imm lands in ALUOut ahead of BRANCH.
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
            end
            S_MEMRD: w_mem_req = 1'b1;
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_result_src = 2'b01;
            end
            S_MEMWR: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
            end
            S_EXEC_R: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b10;
                w_funct3    = bus.instr[14:12];
                w_funct7    = bus.instr[31:25];
            end
            S_EXEC_I: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b10;
                w_funct3    = bus.instr[14:12];
                // Only shifts carry a funct7 bit; ADDI imm[10] must not mean SUB.
                if (bus.instr[14:12] == 3'b101)
                    w_funct7 = {1'b0, bus.instr[30], 5'b00000};
            end
            S_ALUWB: w_reg_write = 1'b1;
            S_BRANCH: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b01;
                w_funct3    = bus.instr[14:12];
                // ALU returns 1 for a true condition, so taken means not zero.
                w_pc_write  = ~bus.zero;
            end
            S_JAL, S_JALR: begin
                // rd = oldPC+4; the datapath jump select picks the PC target.
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b10;
                w_reg_write  = 1'b1;
                w_result_src = 2'b10;
                w_pc_write   = 1'b1;
            end
            S_LUI: begin
                w_alu_src_b  = 2'b01;
                w_reg_write  = 1'b1;
                w_result_src = 2'b10;
            end
            S_AUIPC: begin
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b01;
                w_reg_write  = 1'b1;
                w_result_src = 2'b10;
            end
            default: ;
        endcase
    end

    assign w_retire = (r_state == S_MEMWB)  || (r_state == S_MEMWR && bus.mem_ready) ||
                      (r_state == S_ALUWB)  || (r_state == S_BRANCH) ||
                      (r_state == S_JAL)    || (r_state == S_JALR)   ||
                      (r_state == S_LUI)    || (r_state == S_AUIPC);

    // Sticky illegal flag, raised on entry so it is visible in the TRAP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_illegal <= 1'b0;
        else if (w_next == S_TRAP) r_illegal <= 1'b1;
    end

    // Retired-instruction counter; wraps naturally at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_instret <= '0;
        else if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end

    assign bus.mem_req    = w_mem_req;
    assign bus.mem_we     = w_mem_we;
    assign bus.ir_write   = w_ir_write;
    assign bus.pc_write   = w_pc_write;
    assign bus.reg_write  = w_reg_write;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.result_src = w_result_src;
    assign bus.alu_op     = w_alu_op;
    assign bus.funct3     = w_funct3;
    assign bus.funct7     = w_funct7;
    assign o_illegal      = r_illegal;
    assign o_instret      = r_instret;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected state and control
// vectors are queued for each instruction and then compared cycle by cycle.
// dut_a halts on TRAP with a 32-bit counter; dut_b skips traps and uses a
// 2-bit counter so counter wrap is reachable in a few instructions.
module tb_multicycle_control;

    localparam logic [3:0] ST_FETCH  = 4'd0,  ST_DECODE = 4'd1,  ST_MEMADR = 4'd2,
                           ST_MEMRD  = 4'd3,  ST_MEMWB  = 4'd4,  ST_MEMWR  = 4'd5,
                           ST_EXEC_R = 4'd6,  ST_EXEC_I = 4'd7,  ST_ALUWB  = 4'd8,
                           ST_BRANCH = 4'd9,  ST_JAL    = 4'd10, ST_JALR   = 4'd11,
                           ST_LUI    = 4'd12, ST_AUIPC  = 4'd13, ST_IDLE   = 4'd14,
                           ST_TRAP   = 4'd15;

    logic        clk = 1'b0;
    logic        rst_a_n, rst_b_n;
    logic [31:0] r_instr;
    logic        r_zero, r_ready;
    logic        illegal_a, illegal_b;
    logic [31:0] instret_a;
    logic [1:0]  instret_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic        rdy;
        logic        zr;
        logic [26:0] exp;
    } exp_t;

    exp_t sb[$];

    multicycle_control_if bus_a ();
    multicycle_control_if bus_b ();

    assign bus_a.instr     = r_instr;
    assign bus_a.zero      = r_zero;
    assign bus_a.mem_ready = r_ready;
    assign bus_b.instr     = r_instr;
    assign bus_b.zero      = r_zero;
    assign bus_b.mem_ready = r_ready;

    multicycle_control #(.TRAP_HALT(1'b1), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .bus(bus_a), .o_illegal(illegal_a), .o_instret(instret_a)
    );

    multicycle_control #(.TRAP_HALT(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .bus(bus_b), .o_illegal(illegal_b), .o_instret(instret_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    // Control table of the controller, one row per state:
    // {mem_req, mem_we, ir_write, pc_write, reg_write, src_a, src_b, result_src, alu_op, funct3, funct7}
    function automatic logic [22:0] model(input logic [3:0] st, input logic [31:0] ins,
                                          input logic zr, input logic rdy);
        logic       req = 0, we = 0, irw = 0, pcw = 0, rgw = 0;
        logic [1:0] a = 0, b = 0, res = 0, op = 0;
        logic [2:0] f3 = 0;
        logic [6:0] f7 = 0;
        case (st)
            ST_FETCH:  begin req = 1; b = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
            ST_DECODE: begin a = 2'b01; b = 2'b01; end
            ST_MEMADR: begin a = 2'b10; b = 2'b01; end
            ST_MEMRD:  req = 1;
            ST_MEMWB:  begin rgw = 1; res = 2'b01; end
            ST_MEMWR:  begin req = 1; we = 1; end
            ST_EXEC_R: begin a = 2'b10; op = 2'b10; f3 = ins[14:12]; f7 = ins[31:25]; end
            ST_EXEC_I: begin
                a = 2'b10; b = 2'b01; op = 2'b10; f3 = ins[14:12];
                f7 = (ins[14:12] == 3'b101) ? {1'b0, ins[30], 5'b0} : 7'h00;
            end
            ST_ALUWB:  rgw = 1;
            ST_BRANCH: begin a = 2'b10; op = 2'b01; f3 = ins[14:12]; pcw = ~zr; end
            ST_JAL, ST_JALR: begin a = 2'b01; b = 2'b10; rgw = 1; res = 2'b10; pcw = 1; end
            ST_LUI:    begin b = 2'b01; rgw = 1; res = 2'b10; end
            ST_AUIPC:  begin a = 2'b01; b = 2'b01; rgw = 1; res = 2'b10; end
            default: ;
        endcase
        return {req, we, irw, pcw, rgw, a, b, res, op, f3, f7};
    endfunction

    function automatic logic [26:0] obs(input int sel);
        if (sel == 0)
            return {dut_a.r_state, bus_a.mem_req, bus_a.mem_we, bus_a.ir_write, bus_a.pc_write,
                    bus_a.reg_write, bus_a.alu_src_a, bus_a.alu_src_b, bus_a.result_src,
                    bus_a.alu_op, bus_a.funct3, bus_a.funct7};
        return {dut_b.r_state, bus_b.mem_req, bus_b.mem_we, bus_b.ir_write, bus_b.pc_write,
                bus_b.reg_write, bus_b.alu_src_a, bus_b.alu_src_b, bus_b.result_src,
                bus_b.alu_op, bus_b.funct3, bus_b.funct7};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
        end
    endtask

    // Queue one expected cycle using the current instruction.
    task automatic push(input string tag, input logic [3:0] st, input logic rdy, input logic zr);
        exp_t e;
        e.tag = tag;
        e.rdy = rdy;
        e.zr  = zr;
        e.exp = {st, model(st, r_instr, zr, rdy)};
        sb.push_back(e);
    endtask

    // Drain the queue: drive the cycle's inputs, compare at the falling edge.
    task automatic play(input int sel);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            r_ready = e.rdy;
            r_zero  = e.zr;
            @(negedge clk);
            check(e.tag, {5'b0, obs(sel)}, {5'b0, e.exp});
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        r_instr = 32'h0;
        r_zero  = 1'b0;
        r_ready = 1'b1;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state_outputs", {5'b0, obs(0)}, {5'b0, ST_IDLE, 23'h0});
        check("reset_instret", instret_a, 32'd0);
        check("reset_illegal", {31'b0, illegal_a}, 32'd0);
        @(posedge clk);
        #1;
        rst_a_n = 1'b1;

        // ADDI x1,x0,10
        r_instr = 32'h00A00093;
        push("addi_idle", ST_IDLE, 1, 0);
        push("addi_fetch", ST_FETCH, 1, 0);
        push("addi_decode", ST_DECODE, 1, 0);
        push("addi_exec", ST_EXEC_I, 1, 0);
        push("addi_wb", ST_ALUWB, 1, 0);
        play(0);
        check("instret_addi", instret_a, 32'd1);

        // SUB with three memory wait cycles in FETCH
        r_instr = 32'h40B50533;
        for (int i = 0; i < 3; i++) push("sub_fetch_wait", ST_FETCH, 0, 0);
        push("sub_fetch", ST_FETCH, 1, 0);
        push("sub_decode", ST_DECODE, 1, 0);
        push("sub_exec", ST_EXEC_R, 1, 0);
        push("sub_wb", ST_ALUWB, 1, 0);
        play(0);
        check("instret_sub", instret_a, 32'd2);

        // ADDI x1,x0,0x400: imm bit 30 set must not leak into funct7
        r_instr = 32'h40000093;
        push("addi30_fetch", ST_FETCH, 1, 0);
        push("addi30_decode", ST_DECODE, 1, 0);
        push("addi30_exec", ST_EXEC_I, 1, 0);
        push("addi30_wb", ST_ALUWB, 1, 0);
        play(0);

        // SRAI: funct7 carries bit 30; mem_ready low outside memory states
        r_instr = 32'h40105093;
        push("srai_fetch", ST_FETCH, 1, 0);
        push("srai_decode", ST_DECODE, 0, 0);
        push("srai_exec", ST_EXEC_I, 0, 0);
        push("srai_wb", ST_ALUWB, 0, 0);
        play(0);
        check("instret_srai", instret_a, 32'd4);

        // BEQ with zero=1 (not taken) then zero=0 (taken)
        r_instr = 32'h00000063;
        push("beq_z1_fetch", ST_FETCH, 1, 0);
        push("beq_z1_decode", ST_DECODE, 1, 1);
        push("beq_z1_branch", ST_BRANCH, 1, 1);
        push("beq_z0_fetch", ST_FETCH, 1, 0);
        push("beq_z0_decode", ST_DECODE, 1, 0);
        push("beq_z0_branch", ST_BRANCH, 1, 0);
        play(0);
        check("instret_beq", instret_a, 32'd6);

        // LW zero-wait, then LW with one wait in MEMRD
        r_instr = 32'h00012083;
        push("lw_fetch", ST_FETCH, 1, 0);
        push("lw_decode", ST_DECODE, 1, 0);
        push("lw_memadr", ST_MEMADR, 1, 0);
        push("lw_memrd", ST_MEMRD, 1, 0);
        push("lw_memwb", ST_MEMWB, 1, 0);
        push("lw2_fetch", ST_FETCH, 1, 0);
        push("lw2_decode", ST_DECODE, 1, 0);
        push("lw2_memadr", ST_MEMADR, 1, 0);
        push("lw2_memrd_wait", ST_MEMRD, 0, 0);
        push("lw2_memrd", ST_MEMRD, 1, 0);
        push("lw2_memwb", ST_MEMWB, 1, 0);
        play(0);
        check("instret_lw", instret_a, 32'd8);

        // SW with one wait in MEMWR
        r_instr = 32'h00112023;
        push("sw_fetch", ST_FETCH, 1, 0);
        push("sw_decode", ST_DECODE, 1, 0);
        push("sw_memadr", ST_MEMADR, 1, 0);
        push("sw_memwr_wait", ST_MEMWR, 0, 0);
        push("sw_memwr", ST_MEMWR, 1, 0);
        play(0);
        check("instret_sw", instret_a, 32'd9);

        // JAL, JALR, LUI, AUIPC
        r_instr = 32'h0000006F;
        push("jal_fetch", ST_FETCH, 1, 0);
        push("jal_decode", ST_DECODE, 1, 0);
        push("jal_exec", ST_JAL, 1, 0);
        play(0);
        r_instr = 32'h00008067;
        push("jalr_fetch", ST_FETCH, 1, 0);
        push("jalr_decode", ST_DECODE, 1, 0);
        push("jalr_exec", ST_JALR, 1, 0);
        play(0);
        r_instr = 32'h000010B7;
        push("lui_fetch", ST_FETCH, 1, 0);
        push("lui_decode", ST_DECODE, 1, 0);
        push("lui_exec", ST_LUI, 1, 0);
        play(0);
        r_instr = 32'h00001097;
        push("auipc_fetch", ST_FETCH, 1, 0);
        push("auipc_decode", ST_DECODE, 1, 0);
        push("auipc_exec", ST_AUIPC, 1, 0);
        play(0);
        check("instret_jumps", instret_a, 32'd13);

        // LW interrupted by asynchronous reset while waiting in MEMRD
        r_instr = 32'h00012083;
        push("lwrst_fetch", ST_FETCH, 1, 0);
        push("lwrst_decode", ST_DECODE, 1, 0);
        push("lwrst_memadr", ST_MEMADR, 1, 0);
        push("lwrst_memrd", ST_MEMRD, 0, 0);
        play(0);
        check("lwrst_still_memrd", {28'b0, dut_a.r_state}, {28'b0, ST_MEMRD});
        check("lwrst_req_before", {31'b0, bus_a.mem_req}, 32'd1);
        rst_a_n = 1'b0;
        #1;
        check("lwrst_state", {28'b0, dut_a.r_state}, {28'b0, ST_IDLE});
        check("lwrst_mem_req", {31'b0, bus_a.mem_req}, 32'd0);
        check("lwrst_instret", instret_a, 32'd0);
        @(posedge clk);
        #1;
        rst_a_n = 1'b1;

        // Illegal opcode with TRAP_HALT=1: parks in TRAP, illegal sticky
        r_instr = 32'h0000007F;
        push("trap_idle", ST_IDLE, 1, 0);
        push("trap_fetch", ST_FETCH, 1, 0);
        push("trap_decode", ST_DECODE, 1, 0);
        for (int i = 0; i < 3; i++) push("trap_hold", ST_TRAP, 1, 0);
        play(0);
        check("trap_illegal", {31'b0, illegal_a}, 32'd1);
        check("trap_instret", instret_a, 32'd0);

        // dut_b: 2-bit counter wraps 3 -> 0; trap is skipped without retiring
        @(posedge clk);
        #1;
        rst_b_n = 1'b1;
        r_instr = 32'h000010B7;
        push("b_idle", ST_IDLE, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            push("b_lui_fetch", ST_FETCH, 1, 0);
            push("b_lui_decode", ST_DECODE, 1, 0);
            push("b_lui_exec", ST_LUI, 1, 0);
            play(1);
            check($sformatf("b_instret_%0d", i), {30'b0, instret_b}, 32'(i % 4));
        end
        check("b_illegal_clear", {31'b0, illegal_b}, 32'd0);
        r_instr = 32'h0000007F;
        push("b_trap_fetch", ST_FETCH, 1, 0);
        push("b_trap_decode", ST_DECODE, 1, 0);
        push("b_trap", ST_TRAP, 1, 0);
        push("b_trap_refetch", ST_FETCH, 1, 0);
        play(1);
        check("b_trap_illegal", {31'b0, illegal_b}, 32'd1);
        check("b_trap_instret", {30'b0, instret_b}, 32'd0);
        r_instr = 32'h000010B7;
        push("b_after_decode", ST_DECODE, 1, 0);
        push("b_after_lui", ST_LUI, 1, 0);
        play(1);
        check("b_after_instret", {30'b0, instret_b}, 32'd1);
        check("b_after_illegal", {31'b0, illegal_b}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM: the producer end of the ALU control interface (alu_op/funct3/funct7) plus the datapath mux, enable and memory-handshake signals.
- Replaces the combinational main decoder when the core moves to a shared-memory multi-cycle datapath.
- Sequences each RV32I instruction through fetch, decode, execute, memory and writeback states.
- Counts retired instructions.

Parameters:
- TRAP_HALT, 1: 1 = illegal opcode parks the FSM in TRAP; 0 = skip the instruction and return to FETCH.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  instruction register contents (valid from DECODE onward)
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  request is a write
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC from result mux
- reg_write  out  1  register file write
- alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1 latch
- alu_src_b  out  2  00 rs2 latch, 01 immediate, 10 constant 4
- result_src  out  2  00 ALUOut register, 01 memory data, 10 ALU result direct
- alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded
- funct3  out  3  to ALU
- funct7  out  7  to ALU
- illegal  out  1  sticky illegal-opcode flag
- instret  out  CNT_W  retired-instruction count

Behaviour:
- **Reset:** asynchronous; state = IDLE; instret = 0; illegal = 0. All outputs are Moore-decoded, so every enable is 0 in IDLE. Reset mid-access drops mem_req immediately.
- **State codes:** IDLE=14, FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, LUI=12, AUIPC=13, TRAP=15.
- **IDLE:** goes to FETCH on the next clock.
- **FETCH:**
  - Outputs: mem_req=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - Stays in FETCH while mem_ready=0.
  - In the cycle mem_ready=1: ir_write=1, pc_write=1, next state DECODE.
- **DECODE:** alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut). Branches by instr[6:0]:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - any other opcode → TRAP
- **MEMADR:** src_a=10, src_b=01, alu_op=00. Goes to MEMRD for loads, MEMWR for stores.
- **MEMRD:** mem_req=1, result_src=00. Stays until mem_ready=1, then MEMWB.
- **MEMWB:** reg_write=1, result_src=01.
- **MEMWR:** mem_req=1, mem_we=1. Stays until mem_ready=1, then FETCH.
- **EXEC_R:** src_a=10, src_b=00, alu_op=10, funct3=instr[14:12], funct7=instr[31:25].
- **EXEC_I:** src_a=10, src_b=01, alu_op=10, funct3=instr[14:12].
  - funct7 = {1'b0, instr[30], 5'b0} when funct3=101; otherwise 0.
  - This stops ADDI with imm[10]=1 from becoming SUB.
- **ALUWB:** EXEC_R and EXEC_I both go to ALUWB. Outputs: reg_write=1, result_src=00.
- **BRANCH:**
  - Outputs: src_a=10, src_b=00, alu_op=01, funct3=instr[14:12], result_src=00.
  - pc_write = ~zero: the ALU produces 1 when the condition holds, so a taken branch is a nonzero result.
- **JAL:** src_a=01, src_b=10, alu_op=00, reg_write=1, result_src=10 (rd = oldPC+4); pc_write=1, and the PC source is handled by the datapath jump select.
- **JALR:** same rd write as JAL; the PC target comes from rs1+imm via the datapath jump select.
- **LUI:** reg_write=1, result_src=10, src_b=01, and the datapath zeroes operand A.
- **AUIPC:** src_a=01, src_b=01, alu_op=00, reg_write=1, result_src=10.
- **Return to FETCH:** MEMWB, MEMWR, ALUWB, BRANCH, JAL, JALR, LUI and AUIPC all go to FETCH on the next clock.
- **Default outputs:** funct3/funct7 are 0 in all states not listed.
- **TRAP:**
  - illegal is set to 1 and stays 1 until reset; all enables are 0.
  - TRAP_HALT=1: stays in TRAP.
  - TRAP_HALT=0: goes to FETCH next clock; instret does not increment.
- **instret:** increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, JAL, JALR, LUI or AUIPC. It wraps from all-ones to 0.
- **Latency (cycles including fetch, zero-wait memory):**
  - R/I-type: 4
  - Load: 5
  - Store: 4
  - Branch: 3
  - JAL, JALR, LUI, AUIPC: 3
- **Memory handshake:** mem_ready is ignored outside FETCH, MEMRD and MEMWR. mem_req never drops before mem_ready is sampled high.

Test Plan:
- Reset, then release rst_n with mem_ready=1 → IDLE, then FETCH with mem_req=1; ir_write=1 and pc_write=1 in the same cycle.
- Fetch with mem_ready low for 3 cycles → mem_req stays high for 4 cycles; ir_write pulses only in the 4th.
- instr=0x00A00093 (ADDI, imm bit30=0), then instr=0x40B50533 (SUB) → EXEC_I shows funct7=0x00; EXEC_R shows funct7=0x20, alu_op=10; each takes 4 cycles, and instret goes +2.
- BEQ with zero=1, then zero=0 → pc_write in BRANCH is 0, then 1.
- LW with zero-wait memory → 5 cycles with states 0,1,2,3,4; reg_write and result_src=01 in MEMWB. Repeat with an asynchronous reset in MEMRD → state IDLE and mem_req=0 immediately.
- instr opcode 0x7F → TRAP with illegal=1 held (TRAP_HALT=1). With instret preloaded to 0xFFFFFFFF, a subsequent legal retire wraps it to 0.
